// File: rtl/vend_buyer.sv
// Buyer-side controller for a 30-cent can vender: inserts coins from a latched wallet
// one pulse at a time, waits for the can, then tallies the returned change.
module vend_buyer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] n_cnt,
  input  logic [3:0] d_cnt,
  input  logic [3:0] q_cnt,
  input  logic       DC,
  input  logic       DN,
  input  logic       DD,
  output logic       N,
  output logic       D,
  output logic       Q,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] spent,
  output logic [5:0] change
);

  typedef enum logic [2:0] {IDLE, INSERT, GAP, WAIT_DC, WAIT_CHG, DONE, ERR} state_t;
  typedef enum logic [1:0] {C_N, C_D, C_Q} coin_t;

  state_t     state;
  coin_t      pick;
  logic [3:0] n_w, d_w, q_w;
  logic [9:0] wval;
  logic [2:0] tmo;
  logic [5:0] need;
  logic [6:0] ret_add, chg_next, exp_chg;

  always_comb begin
    need     = 6'd30 - spent;
    pick     = C_Q;
    if (need >= 6'd25 && q_w != '0)      pick = C_Q;
    else if (need >= 6'd10 && d_w != '0) pick = C_D;
    else if (n_w != '0)                  pick = C_N;
    else if (d_w != '0)                  pick = C_D;
    ret_add  = (DN ? 7'd5 : 7'd0) + (DD ? 7'd10 : 7'd0);
    chg_next = {1'b0, change} + ret_add;
    exp_chg  = {1'b0, spent} - 7'd30;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      N      <= 1'b0;
      D      <= 1'b0;
      Q      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      spent  <= '0;
      change <= '0;
      n_w    <= '0;
      d_w    <= '0;
      q_w    <= '0;
      wval   <= '0;
      tmo    <= '0;
    end else begin
      N <= 1'b0;
      D <= 1'b0;
      Q <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            n_w    <= n_cnt;
            d_w    <= d_cnt;
            q_w    <= q_cnt;
            wval   <= 10'(n_cnt) * 10'd5 + 10'(d_cnt) * 10'd10 + 10'(q_cnt) * 10'd25;
            spent  <= '0;
            change <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
            busy   <= 1'b1;
            tmo    <= '0;
            state  <= INSERT;
          end
        end
        INSERT: begin
          // First INSERT cycle (spent still 0) doubles as the affordability check
          // on the registered wallet value, so a short wallet never pulses a coin.
          if (spent == '0 && wval < 10'd30) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else begin
            case (pick)
              C_Q: begin Q <= 1'b1; q_w <= q_w - 4'd1; spent <= spent + 6'd25; end
              C_D: begin D <= 1'b1; d_w <= d_w - 4'd1; spent <= spent + 6'd10; end
              default: begin N <= 1'b1; n_w <= n_w - 4'd1; spent <= spent + 6'd5; end
            endcase
            state <= GAP;
          end
        end
        GAP: begin
          if (spent < 6'd30) state <= INSERT;
          else begin
            tmo   <= '0;
            state <= WAIT_DC;
          end
        end
        WAIT_DC: begin
          change <= chg_next[5:0];
          if (DC) begin
            tmo <= '0;
            if (spent == 6'd30) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else state <= WAIT_CHG;
          end else if (tmo == 3'd3) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else tmo <= tmo + 3'd1;
        end
        WAIT_CHG: begin
          change <= chg_next[5:0];
          if (chg_next == exp_chg) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (chg_next > exp_chg || (ret_add == '0 && tmo == 3'd5)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else if (ret_add == '0) tmo <= tmo + 3'd1;
          else tmo <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_buyer.sv
// Scoreboard bench for vend_buyer: driver pushes predicted coins/results, monitor pops
// and compares; a vender model answers coin pulses with DC and change returns.
module tb_vend_buyer;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] n_cnt, d_cnt, q_cnt;
  logic       DC, DN, DD;
  logic       N, D, Q, busy, done, error;
  logic [5:0] spent, change;

  vend_buyer dut (
    .clk(clk), .reset(reset), .start(start), .n_cnt(n_cnt), .d_cnt(d_cnt), .q_cnt(q_cnt),
    .DC(DC), .DN(DN), .DD(DD), .N(N), .D(D), .Q(Q), .busy(busy), .done(done),
    .error(error), .spent(spent), .change(change)
  );

  always #5 clk = ~clk;

  typedef struct {bit err; int spent; int change; int lat;} res_t;

  int   checks = 0, failures = 0;
  int   coin_q[$];
  res_t res_q[$];
  int   plan_q[$];
  int   t_neg = 0, start_neg = 0, res_cnt = 0;
  bit   prev_coin = 0, prev_fin = 0;
  int   v_total = 0, v_dly = 0;
  int   v_ret[$];
  bit   v_armed = 0, v_active = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int coin_val();
    return int'(N) * 5 + int'(D) * 10 + int'(Q) * 25;
  endfunction

  // Coins the buyer should insert for a wallet; fills plan_q, returns cents spent.
  function automatic int coin_plan(input int n, input int d, input int q);
    int sp = 0;
    int c;
    plan_q.delete();
    while (sp < 30) begin
      if (30 - sp >= 25 && q > 0)      begin c = 25; q--; end
      else if (30 - sp >= 10 && d > 0) begin c = 10; d--; end
      else if (n > 0)                  begin c = 5;  n--; end
      else if (d > 0)                  begin c = 10; d--; end
      else                             begin c = 25; q--; end
      plan_q.push_back(c);
      sp += c;
    end
    return sp;
  endfunction

  // Monitor / scoreboard
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      t_neg++;
      if (!reset) begin
        prev_coin = 0;
        prev_fin  = 0;
      end else begin
        if (N | D | Q) begin
          check("coin_onehot", int'(N) + int'(D) + int'(Q), 1);
          check("coin_gap", int'(prev_coin), 0);
          check("busy_during_coin", int'(busy), 1);
          if (coin_q.size() == 0) check("unexpected_coin", coin_val(), 0);
          else check("coin_value", coin_val(), coin_q.pop_front());
        end
        prev_coin = N | D | Q;
        if ((done | error) && !prev_fin) begin
          if (res_q.size() == 0) check("unexpected_result", int'(done | error), 0);
          else begin
            r = res_q.pop_front();
            check("outcome_error", int'(error), int'(r.err));
            check("outcome_done", int'(done), int'(!r.err));
            check("final_spent", int'(spent), r.spent);
            check("final_change", int'(change), r.change);
            check("busy_at_end", int'(busy), 0);
            check("coins_missing", coin_q.size(), 0);
            if (r.lat > 0) check("err_latency", t_neg - start_neg, r.lat);
          end
          res_cnt++;
        end
        prev_fin = done | error;
      end
    end
  end

  // Vender model: counts inserted cents, then drops a can and returns change
  initial begin
    int r;
    DC = 0; DN = 0; DD = 0;
    forever begin
      @(negedge clk);
      if (reset && v_armed && (N | D | Q)) begin
        v_total += coin_val();
        if (v_total >= 30) begin
          v_armed = 0;
          if (v_dly > 0) begin
            v_active = 1;
            repeat (v_dly) @(negedge clk);
            DC = 1;
            @(negedge clk);
            DC = 0;
            while (v_ret.size() > 0) begin
              r  = v_ret.pop_front();
              DN = (r == 5 || r == 15);
              DD = (r == 10 || r == 15);
              @(negedge clk);
            end
            DN = 0; DD = 0;
            v_active = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    coin_q.delete(); res_q.delete();
    v_armed = 0; v_total = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  // mode: 0 dimes-first exact, 1 nickels, 2 over-return, 3 under-return, 4 combined 15s
  task automatic run_txn(input int n, input int d, input int q, input int dly, input int mode);
    res_t r;
    int   wv, sp, exp_c, rem, sum, target;
    bit   found;
    int   ret[$];
    wv = 5 * n + 10 * d + 25 * q;
    r.lat = 0; r.change = 0;
    if (wv < 30) begin
      r.err = 1; r.spent = 0; r.lat = 2;
    end else begin
      sp = coin_plan(n, d, q);
      foreach (plan_q[i]) coin_q.push_back(plan_q[i]);
      r.spent = sp;
      exp_c = sp - 30;
      rem = exp_c;
      if (mode == 4) while (rem >= 15) begin ret.push_back(15); rem -= 15; end
      if (mode == 1) while (rem >= 5) begin ret.push_back(5); rem -= 5; end
      while (rem >= 10) begin ret.push_back(10); rem -= 10; end
      if (rem == 5) ret.push_back(5);
      if (mode == 2 && ret.size() > 0) ret[ret.size() - 1] = ret[ret.size() - 1] + 5;
      if (mode == 3 && ret.size() > 0) void'(ret.pop_back());
      if (dly == 0) r.err = 1;
      else if (exp_c == 0) r.err = 0;
      else begin
        sum = 0; found = 0; r.err = 1;
        foreach (ret[i]) if (!found) begin
          sum += ret[i];
          if (sum == exp_c) begin r.err = 0; found = 1; end
          else if (sum > exp_c) found = 1;
        end
        r.change = sum;
      end
    end
    res_q.push_back(r);
    v_total = 0; v_dly = dly; v_ret = ret; v_armed = (wv >= 30);
    target = res_cnt + 1;
    @(negedge clk);
    n_cnt = 4'(n); d_cnt = 4'(d); q_cnt = 4'(q);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    start_neg = t_neg;
    for (int i = 0; i < 300 && res_cnt < target; i++) @(negedge clk);
    if (res_cnt < target) begin
      check("result_timeout", res_cnt, target);
      do_reset();
    end
    for (int i = 0; i < 100 && v_active; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; n_cnt = '0; d_cnt = '0; q_cnt = '0;
    #2 reset = 0;
    #1 check("reset_state", int'({N, D, Q, busy, done, error, spent, change}), 0);
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);

    run_txn(0, 0, 2, 2, 0);   // two quarters, 20c back in dimes
    run_txn(6, 0, 0, 1, 0);   // six nickels, exact
    run_txn(0, 1, 1, 3, 1);   // Q then D overpay, one nickel back
    run_txn(2, 1, 0, 1, 0);   // 20c wallet: error, no coins
    run_txn(6, 0, 0, 0, 0);   // no can: WAIT_DC timeout
    run_txn(0, 1, 1, 4, 2);   // extra change returned: error
    run_txn(0, 0, 2, 1, 3);   // short change: WAIT_CHG timeout
    run_txn(0, 0, 2, 2, 4);   // combined DN+DD return

    // Reset during the GAP following the first coin
    coin_plan(6, 0, 0);
    foreach (plan_q[i]) coin_q.push_back(plan_q[i]);
    res_q.push_back('{0, 30, 0, 0});
    v_total = 0; v_dly = 1; v_armed = 1;
    @(negedge clk);
    n_cnt = 4'd6; d_cnt = '0; q_cnt = '0; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int i = 0; i < 10 && !N; i++) @(negedge clk);
    check("mid_first_coin", int'(N), 1);
    #1 reset = 0;
    #1 check("mid_reset_outputs", int'({N, D, Q, busy, done, error, spent, change}), 0);
    coin_q.delete(); res_q.delete(); v_armed = 0;
    repeat (3) @(negedge clk);
    check("held_reset_outputs", int'({N, D, Q, busy, done, error, spent, change}), 0);
    reset = 1;
    repeat (2) @(negedge clk);
    run_txn(6, 0, 0, 2, 0);

    for (int k = 0; k < 40; k++) begin
      int n, d, q, dly;
      n = $urandom_range(0, 6);
      d = $urandom_range(0, 3);
      q = $urandom_range(0, 2);
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      run_txn(n, d, q, dly, $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
